uart_loader: RTL and testbench



---
 rtl/uart_loader_pkg.sv | 33 +++
 rtl/uart_loader_if.sv | 35 +++
 rtl/uart_loader_txq.sv | 64 ++++++
 rtl/uart_loader.sv | 196 +++++++++++++++++++
 tb/tb_uart_loader.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared constants and state encoding for the UART boot loader
//
// Purpose: opcode/reply byte values and the command FSM state type used by
// uart_loader. No ports.

package uart_loader_pkg;

  // Command opcodes received in IDLE
  localparam logic [7:0] OP_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] OP_GO   = 8'h47;  // 'G'

  // One-byte replies sent back through the transmit queue
  localparam logic [7:0] RSP_OK  = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_ERR = 8'h45;  // 'E'
  localparam logic [7:0] RSP_UNK = 8'h3F;  // '?'
  localparam logic [7:0] RSP_TMO = 8'h54;  // 'T'

  // State codes kept as plain constants so older code can compare raw bits
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADDR = 3'd1;
  localparam logic [2:0] ST_LEN  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_CSUM = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    ADDR = ST_ADDR,
    LEN  = ST_LEN,
    DATA = ST_DATA,
    CSUM = ST_CSUM
  } state_e;

endpackage

// File: rtl/uart_loader_if.sv
// rtl/uart_loader_if.sv - UART/memory/core-reset signal bundle of the boot loader
//
// Purpose: groups the loader's serial, memory-write and core-reset signals.
//   rx_dat/rx_en          received byte + one-cycle valid pulse
//   tx_rd/tx_empty/tx_dat show-ahead reply byte read port
//   mem_we/mem_addr/mem_wdat/mem_be  64-bit word write port
//   cpu_rst_n             core reset, active low
// Modports: slave = loader side, master = UART/memory/core side.

interface uart_loader_if #(
  parameter int ADDR_W = 16
);

  logic [7:0]        rx_dat;
  logic              rx_en;
  logic              tx_rd;
  logic              tx_empty;
  logic [7:0]        tx_dat;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdat;
  logic [7:0]        mem_be;
  logic              cpu_rst_n;

  modport slave (
    input  rx_dat, rx_en, tx_rd,
    output tx_empty, tx_dat, mem_we, mem_addr, mem_wdat, mem_be, cpu_rst_n
  );

  modport master (
    output rx_dat, rx_en, tx_rd,
    input  tx_empty, tx_dat, mem_we, mem_addr, mem_wdat, mem_be, cpu_rst_n
  );

endinterface

// File: rtl/uart_loader_txq.sv
// rtl/uart_loader_txq.sv - one-deep reply queue with output hold timer
//
// Purpose: holds one pending reply plus the byte currently offered to the
// UART transmitter. After each read the output byte is kept stable for
// HOLD_CYC cycles so the transmitter can shift it out.
// Ports:
//   CLK, RST        clock, synchronous active-low reset
//   push, push_dat  one-cycle strobe queueing a reply byte
//   tx_rd           read pulse from the transmitter
//   tx_empty        0 = tx_dat holds an unread reply
//   tx_dat          reply byte

module uart_loader_txq #(
  parameter int HOLD_CYC = 2000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       push,
  input  logic [7:0] push_dat,
  input  logic       tx_rd,
  output logic       tx_empty,
  output logic [7:0] tx_dat
);

  localparam int CW = $clog2(HOLD_CYC + 1);

  logic [CW-1:0] hold_cnt;
  logic          pend_vld;
  logic [7:0]    pend_dat;
  logic          load;

  // Pending byte moves out only once the previous byte has been read and
  // its hold window has fully elapsed.
  assign load = tx_empty && (hold_cnt == '0) && pend_vld;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      tx_empty <= 1'b1;
      tx_dat   <= 8'h00;
      hold_cnt <= '0;
      pend_vld <= 1'b0;
      pend_dat <= 8'h00;
    end else begin
      if (!tx_empty && tx_rd) begin
        tx_empty <= 1'b1;
        hold_cnt <= CW'(HOLD_CYC);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - CW'(1);
      end else if (load) begin
        tx_empty <= 1'b0;
        tx_dat   <= pend_dat;
      end

      // A push into a full pending slot is dropped; the older reply wins.
      if (push && !pend_vld) begin
        pend_vld <= 1'b1;
        pend_dat <= push_dat;
      end else if (load) begin
        pend_vld <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - serial boot loader: command decode, memory writes, core reset
//
// Purpose: decodes the received byte stream ('L' load, 'G' go), packs load
// data into 64-bit little-endian words with byte enables, holds the core in
// reset until 'G', and queues one-byte replies for the transmitter.
// Ports:
//   CLK, RST  clock, synchronous active-low reset
//   bus       uart_loader_if.slave: rx_dat/rx_en in, tx_rd in,
//             tx_empty/tx_dat, mem_we/mem_addr/mem_wdat/mem_be, cpu_rst_n out
// Build option: UART_LOADER_TIMEOUT_EN adds an inter-byte timeout that
// abandons a command after TIMEOUT_CYC idle cycles and replies 'T'.

module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int HOLD_CYC = 2000
`ifdef UART_LOADER_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 200000
`endif
) (
  input  logic         CLK,
  input  logic         RST,
  uart_loader_if.slave bus
);

  state_e            state;
  logic [1:0]        byte_cnt;
  logic [31:0]       addr;       // byte address, advances per data byte
  logic [15:0]       len_cnt;    // length while parsing, then bytes remaining
  logic [7:0]        sum;
  logic [63:0]       wdat_acc;
  logic [7:0]        be_acc;
  logic              cpu_rst_n_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [63:0]       mem_wdat_q;
  logic [7:0]        mem_be_q;
  logic              rsp_push;
  logic [7:0]        rsp_dat;

  logic [2:0]        lane;
  logic [63:0]       acc_nxt;
  logic [7:0]        be_nxt;
  logic              last;
  logic              flush;
  logic              tmo_hit;
  logic              unused_addr_hi;

  // Address bits above the word address only matter for carry-out; words wrap.
  assign unused_addr_hi = ^addr[31:ADDR_W+3];

  always_comb begin
    lane                      = addr[2:0];
    acc_nxt                   = wdat_acc;
    acc_nxt[{lane, 3'b000} +: 8] = bus.rx_dat;
    be_nxt                    = be_acc | (8'd1 << lane);
    last                      = (len_cnt == 16'd1);
    // Lane 7 filled and final byte may coincide; still a single write.
    flush                     = (lane == 3'd7) || last;
  end

`ifdef UART_LOADER_TIMEOUT_EN
  logic [31:0] tmo_cnt;

  always_ff @(posedge CLK) begin
    if (!RST || bus.rx_en || state == IDLE) begin
      tmo_cnt <= 32'd0;
    end else if (tmo_cnt != 32'(TIMEOUT_CYC)) begin
      tmo_cnt <= tmo_cnt + 32'd1;
    end
  end

  // A byte arriving on the expiry cycle still counts; it is not a timeout.
  assign tmo_hit = (state != IDLE) && !bus.rx_en && (tmo_cnt == 32'(TIMEOUT_CYC));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state       <= IDLE;
      byte_cnt    <= 2'd0;
      addr        <= 32'd0;
      len_cnt     <= 16'd0;
      sum         <= 8'h00;
      wdat_acc    <= 64'd0;
      be_acc      <= 8'h00;
      cpu_rst_n_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdat_q  <= 64'd0;
      mem_be_q    <= 8'h00;
      rsp_push    <= 1'b0;
      rsp_dat     <= 8'h00;
    end else begin
      mem_we_q <= 1'b0;
      rsp_push <= 1'b0;

      if (tmo_hit) begin
        state    <= IDLE;
        byte_cnt <= 2'd0;
        wdat_acc <= 64'd0;
        be_acc   <= 8'h00;
        rsp_push <= 1'b1;
        rsp_dat  <= RSP_TMO;
      end else if (bus.rx_en) begin
        case (state)
          IDLE: begin
            if (bus.rx_dat == OP_LOAD) begin
              state    <= ADDR;
              byte_cnt <= 2'd0;
              sum      <= 8'h00;
              wdat_acc <= 64'd0;
              be_acc   <= 8'h00;
            end else if (bus.rx_dat == OP_GO) begin
              cpu_rst_n_q <= 1'b1;
              rsp_push    <= 1'b1;
              rsp_dat     <= RSP_OK;
            end else begin
              rsp_push <= 1'b1;
              rsp_dat  <= RSP_UNK;
            end
          end

          ADDR: begin
            // Little-endian: shift in from the top so byte 0 ends in [7:0]
            addr     <= {bus.rx_dat, addr[31:8]};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              state    <= LEN;
              byte_cnt <= 2'd0;
            end
          end

          LEN: begin
            len_cnt <= {bus.rx_dat, len_cnt[15:8]};
            if (byte_cnt == 2'd1) begin
              byte_cnt <= 2'd0;
              state    <= ({bus.rx_dat, len_cnt[15:8]} == 16'd0) ? CSUM : DATA;
            end else begin
              byte_cnt <= 2'd1;
            end
          end

          DATA: begin
            addr    <= addr + 32'd1;
            sum     <= sum + bus.rx_dat;
            len_cnt <= len_cnt - 16'd1;
            if (flush) begin
              mem_we_q   <= 1'b1;
              mem_addr_q <= addr[ADDR_W+2:3];
              mem_wdat_q <= acc_nxt;
              mem_be_q   <= be_nxt;
              wdat_acc   <= 64'd0;
              be_acc     <= 8'h00;
            end else begin
              wdat_acc <= acc_nxt;
              be_acc   <= be_nxt;
            end
            if (last) begin
              state <= CSUM;
            end
          end

          CSUM: begin
            rsp_push <= 1'b1;
            rsp_dat  <= (bus.rx_dat == sum) ? RSP_OK : RSP_ERR;
            state    <= IDLE;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdat  = mem_wdat_q;
  assign bus.mem_be    = mem_be_q;
  assign bus.cpu_rst_n = cpu_rst_n_q;

  uart_loader_txq #(
    .HOLD_CYC (HOLD_CYC)
  ) u_txq (
    .CLK      (CLK),
    .RST      (RST),
    .push     (rsp_push),
    .push_dat (rsp_dat),
    .tx_rd    (bus.tx_rd),
    .tx_empty (bus.tx_empty),
    .tx_dat   (bus.tx_dat)
  );

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - directed self-checking bench for uart_loader

module tb_uart_loader;

  localparam int HOLD = 2000;

  logic CLK = 1'b0;
  logic RST;

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] w_addr[$];
  logic [63:0] w_dat[$];
  logic [7:0]  w_be[$];

  uart_loader_if #(.ADDR_W(16)) bus ();

  uart_loader #(
    .ADDR_W   (16),
    .HOLD_CYC (HOLD)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (bus.mem_we === 1'b1) begin
      w_addr.push_back(bus.mem_addr);
      w_dat.push_back(bus.mem_wdat);
      w_be.push_back(bus.mem_be);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge CLK);
    bus.rx_dat = b;
    bus.rx_en  = 1'b1;
    @(negedge CLK);
    bus.rx_en  = 1'b0;
    repeat (3) @(negedge CLK);
  endtask

  // Waits (bounded) for a reply, returns it and reads it; 0x00 if none arrives.
  task automatic get_reply(output logic [7:0] b);
    logic got;
    got = 1'b0;
    b   = 8'h00;
    for (int i = 0; i < HOLD + 200; i++) begin
      if (!got && bus.tx_empty === 1'b0) begin
        got = 1'b1;
        b   = bus.tx_dat;
      end
      if (!got) @(negedge CLK);
    end
    if (got) begin
      bus.tx_rd = 1'b1;
      @(negedge CLK);
      bus.tx_rd = 1'b0;
    end
  endtask

  task automatic load_hdr(input logic [31:0] a, input logic [15:0] n);
    send(8'h4C);
    for (int i = 0; i < 4; i++) send(a[i*8 +: 8]);
    send(n[7:0]);
    send(n[15:8]);
  endtask

  initial begin
    logic [7:0] r;
    int         base;
    int         hold_seen;
    logic       stable;

    RST        = 1'b0;
    bus.rx_dat = 8'h00;
    bus.rx_en  = 1'b0;
    bus.tx_rd  = 1'b0;
    repeat (3) @(negedge CLK);

    chk("rst_tx_empty",  {63'd0, bus.tx_empty}, 64'd1);
    chk("rst_tx_dat",    {56'd0, bus.tx_dat},   64'd0);
    chk("rst_mem_we",    {63'd0, bus.mem_we},   64'd0);
    chk("rst_mem_addr",  {48'd0, bus.mem_addr}, 64'd0);
    chk("rst_mem_wdat",  bus.mem_wdat,          64'd0);
    chk("rst_mem_be",    {56'd0, bus.mem_be},   64'd0);
    chk("rst_cpu_rst_n", {63'd0, bus.cpu_rst_n}, 64'd0);

    RST = 1'b1;
    repeat (2) @(negedge CLK);

    // Aligned load of 8 bytes
    load_hdr(32'h0000_0000, 16'd8);
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'h24);
    get_reply(r);
    chk("al_reply",  {56'd0, r}, 64'h4B);
    chk("al_nwr",    64'(w_addr.size()), 64'd1);
    chk("al_addr",   {48'd0, w_addr[0]}, 64'd0);
    chk("al_wdat",   w_dat[0], 64'h0807_0605_0403_0201);
    chk("al_be",     {56'd0, w_be[0]}, 64'hFF);
    chk("al_cpu_rst", {63'd0, bus.cpu_rst_n}, 64'd0);

    // Unaligned load crossing a word boundary
    load_hdr(32'h0000_0006, 16'd3);
    send(8'hAA); send(8'hBB); send(8'hCC);
    send(8'h31);
    get_reply(r);
    chk("un_reply", {56'd0, r}, 64'h4B);
    chk("un_nwr",   64'(w_addr.size()), 64'd3);
    chk("un_addr0", {48'd0, w_addr[1]}, 64'd0);
    chk("un_be0",   {56'd0, w_be[1]}, 64'hC0);
    chk("un_wdat0", w_dat[1], 64'hBBAA_0000_0000_0000);
    chk("un_addr1", {48'd0, w_addr[2]}, 64'd1);
    chk("un_be1",   {56'd0, w_be[2]}, 64'h01);
    chk("un_wdat1", w_dat[2], 64'h0000_0000_0000_00CC);

    // Bad checksum: write still happens, reply 'E'
    load_hdr(32'h0000_0000, 16'd8);
    for (int i = 1; i <= 8; i++) send(8'(i));
    send(8'h00);
    get_reply(r);
    chk("bc_reply", {56'd0, r}, 64'h45);
    chk("bc_nwr",   64'(w_addr.size()), 64'd4);
    chk("bc_wdat",  w_dat[3], 64'h0807_0605_0403_0201);
    chk("bc_be",    {56'd0, w_be[3]}, 64'hFF);

    // Zero-length load: straight to checksum, no write
    load_hdr(32'h0000_0100, 16'd0);
    send(8'h00);
    get_reply(r);
    chk("z_reply", {56'd0, r}, 64'h4B);
    chk("z_nwr",   64'(w_addr.size()), 64'd4);

    // Go and unknown opcode
    send(8'h47);
    chk("go_cpu_rst", {63'd0, bus.cpu_rst_n}, 64'd1);
    get_reply(r);
    chk("go_reply", {56'd0, r}, 64'h4B);
    send(8'h55);
    get_reply(r);
    chk("unk_reply", {56'd0, r}, 64'h3F);

    // Hold window: three 'G' while the core already runs; the third is dropped
    repeat (HOLD + 10) @(negedge CLK);
    send(8'h47); send(8'h47); send(8'h47);
    chk("ho_cpu_rst", {63'd0, bus.cpu_rst_n}, 64'd1);
    chk("ho_first_empty", {63'd0, bus.tx_empty}, 64'd0);
    get_reply(r);
    chk("ho_first", {56'd0, r}, 64'h4B);
    hold_seen = 0;
    stable    = 1'b1;
    while (bus.tx_empty === 1'b1 && hold_seen < HOLD + 100) begin
      if (bus.tx_dat !== 8'h4B) stable = 1'b0;
      hold_seen++;
      @(negedge CLK);
    end
    chk("ho_len_ok", {63'd0, (hold_seen >= HOLD) && (hold_seen <= HOLD + 1)}, 64'd1);
    chk("ho_stable", {63'd0, stable}, 64'd1);
    chk("ho_second_empty", {63'd0, bus.tx_empty}, 64'd0);
    get_reply(r);
    chk("ho_second", {56'd0, r}, 64'h4B);
    repeat (HOLD + 50) @(negedge CLK);
    chk("ho_third_dropped", {63'd0, bus.tx_empty}, 64'd1);

    // Reset in the middle of a data phase
    base = w_addr.size();
    load_hdr(32'h0000_0010, 16'd8);
    send(8'h11); send(8'h22); send(8'h33);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (20) @(negedge CLK);
    chk("mr_nwr",      64'(w_addr.size() - base), 64'd0);
    chk("mr_cpu_rst",  {63'd0, bus.cpu_rst_n}, 64'd0);
    chk("mr_tx_empty", {63'd0, bus.tx_empty}, 64'd1);
    send(8'h47);
    chk("mr_go_cpu_rst", {63'd0, bus.cpu_rst_n}, 64'd1);
    get_reply(r);
    chk("mr_go_reply", {56'd0, r}, 64'h4B);
    chk("mr_nwr_end",  64'(w_addr.size() - base), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
